// File: rtl/mdu_if.sv
// Request/response bundle between the pipeline (master) and the multiply/divide unit (slave).
// Request:  Start, Op, MTHI, MTLO, A, B, Sel  (pipeline -> mdu)
// Response: RD, Busy, HI, LO                  (mdu -> pipeline)
interface mdu_if;
    logic        Start;
    logic [2:0]  Op;
    logic        MTHI;
    logic        MTLO;
    logic [31:0] A;
    logic [31:0] B;
    logic        Sel;
    logic [31:0] RD;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, Op, MTHI, MTLO, A, B, Sel,
        input  RD, Busy, HI, LO
    );

    modport slave (
        input  Start, Op, MTHI, MTLO, A, B, Sel,
        output RD, Busy, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit holding HI/LO; mult/div results commit to HI/LO after a fixed latency.
// Latency: MULT_CYCLES (mult/multu/madd/maddu) or DIV_CYCLES (div/divu) cycles of Busy; RD is combinational.
// Backpressure: no handshake; Start and MTHI/MTLO are dropped while Busy, the hazard unit stalls on Busy.
//
// Ports: clk, reset (synchronous, active-high), bus (mdu_if.slave):
//   Start/Op launch an operation, MTHI/MTLO write A into HI/LO when idle,
//   Sel picks HI (1) or LO (0) onto RD, Busy flags an operation in flight,
//   HI/LO expose the committed registers.
// Optional feature: define MDU_MADD_EN to enable madd (Op 100) / maddu (Op 101);
// without it those codes are reserved and ignored like any other reserved Op.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   sh_hi;
    logic [31:0]   sh_lo;
    logic          sh_commit;

    // ------------------------------------------------------------------
    // Datapath: products and a single magnitude divider shared by div/divu
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign prod_s = 64'($signed(bus.A)) * 64'($signed(bus.B));
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Op[0] clear means signed divide. Working on magnitudes keeps
    // 0x80000000 / -1 well defined: |A| = 0x80000000, quotient negates back
    // to 0x80000000 with remainder 0, no overflow case to special-case.
    assign div_signed = ~bus.Op[0];
    assign a_mag = (div_signed && bus.A[31]) ? -bus.A : bus.A;
    assign b_mag = (div_signed && bus.B[31]) ? -bus.B : bus.B;
    // Divide-by-zero result is never committed; substitute 1 so the
    // divider never sees a zero divisor.
    assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quo_s = (bus.A[31] ^ bus.B[31]) ? -q_mag : q_mag;
    assign rem_s = bus.A[31] ? -r_mag : r_mag;

    // ------------------------------------------------------------------
    // Op decode and result selection
    // ------------------------------------------------------------------
    logic          op_valid;
    logic          res_commit;
    logic [63:0]   res;
    logic [CW-1:0] n_load;

    always_comb begin
        op_valid   = 1'b0;
        res_commit = 1'b1;
        res        = 64'd0;
        n_load     = CW'(MULT_CYCLES);
        case (bus.Op)
            3'b000: begin
                op_valid = 1'b1;
                res      = prod_s;
            end
            3'b001: begin
                op_valid = 1'b1;
                res      = prod_u;
            end
            3'b010: begin
                op_valid   = 1'b1;
                n_load     = CW'(DIV_CYCLES);
                res_commit = (bus.B != 32'd0);
                res        = {rem_s, quo_s};
            end
            3'b011: begin
                op_valid   = 1'b1;
                n_load     = CW'(DIV_CYCLES);
                res_commit = (bus.B != 32'd0);
                res        = {r_mag, q_mag};
            end
`ifdef MDU_MADD_EN
            // Accumulate against the committed HI/LO sampled at Start.
            3'b100: begin
                op_valid = 1'b1;
                res      = {hi_q, lo_q} + prod_s;
            end
            3'b101: begin
                op_valid = 1'b1;
                res      = {hi_q, lo_q} + prod_u;
            end
`endif
            default: begin
                op_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State: countdown, shadow result, committed HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            sh_hi     <= 32'd0;
            sh_lo     <= 32'd0;
            sh_commit <= 1'b0;
        end else if (cnt != '0) begin
            // Busy: Start and MT writes are both dropped here.
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && sh_commit) begin
                hi_q <= sh_hi;
                lo_q <= sh_lo;
            end
        end else if (bus.Start && op_valid) begin
            // Start wins over a coincident MTHI/MTLO.
            cnt       <= n_load;
            sh_hi     <= res[63:32];
            sh_lo     <= res[31:0];
            sh_commit <= res_commit;
        end else begin
            if (bus.MTHI) hi_q <= bus.A;
            if (bus.MTLO) lo_q <= bus.A;
        end
    end

    assign bus.Busy = (cnt != '0);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.RD   = bus.Sel ? hi_q : lo_q;

endmodule
